// File: rtl/datapath_sequencer.sv
// Microprogrammed sequencer for datapath2: steps through a loadable 16-word
// micro-program and drives the 16-bit control word. Each run is framed by start/done and guarded by a step watchdog.
module datapath_sequencer #(
  parameter int MAX_STEPS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  banderas,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [23:0] prog_data,
  output logic [15:0] control,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [3:0]  upc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_NEXT   = 2'b00,
    OP_JUMP   = 2'b01,
    OP_BRANCH = 2'b10,
    OP_END    = 2'b11
  } seq_op_t;

  localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

  state_t      state;
  logic [7:0]  step_cnt;
  logic [7:0]  step_next;
  logic [23:0] mem [16];
  logic [23:0] word;
  seq_op_t     op;
  logic [1:0]  flag_idx;
  logic [3:0]  target;
  logic [3:0]  upc_adv;
  logic [3:0]  upc_nxt;

  // Program memory has no reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && state == S_IDLE)
      mem[prog_addr] <= prog_data;
  end

  assign word     = mem[upc];
  assign op       = seq_op_t'(word[23:22]);
  assign flag_idx = word[21:20];
  assign target   = word[19:16];
  assign upc_adv  = upc + 4'd1;
  assign step_next = step_cnt + 8'd1;
  assign control  = (state == S_RUN) ? word[15:0] : 16'h0000;

  always_comb begin
    upc_nxt = upc_adv;
    unique case (op)
      OP_NEXT:   upc_nxt = upc_adv;
      OP_JUMP:   upc_nxt = target;
      OP_BRANCH: upc_nxt = banderas[flag_idx] ? target : upc_adv;
      OP_END:    upc_nxt = upc;
    endcase
  end

  // END is tested before the watchdog so a run finishing on its last allowed step is not flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      upc      <= 4'd0;
      step_cnt <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_RUN;
            upc      <= 4'd0;
            step_cnt <= 8'd0;
            timeout  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_RUN: begin
          step_cnt <= step_next;
          if (op == OP_END) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (step_next == STEP_LIMIT) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            upc <= upc_nxt;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: directed micro-programs with hand-computed
// per-cycle expectations, checked by independent monitors on two instances.
module tb_datapath_sequencer;

  typedef struct packed {
    logic [15:0] ctl;
    logic [3:0]  upc;
    logic        chk_upc;
    logic        busy;
    logic        done;
    logic        tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic [3:0]  banderas = 4'd0;
  logic        prog_we = 1'b0, prog_we2 = 1'b0;
  logic [3:0]  prog_addr = 4'd0, prog_addr2 = 4'd0;
  logic [23:0] prog_data = 24'd0, prog_data2 = 24'd0;
  logic [15:0] control, control2;
  logic        busy, busy2, done, done2, timeout, timeout2;
  logic [3:0]  upc, upc2;

  exp_t q0[$];
  exp_t q1[$];
  bit   mon_en = 1'b1;
  int   checks = 0;
  int   failures = 0;

  datapath_sequencer #(.MAX_STEPS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .banderas(banderas),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .control(control), .busy(busy), .done(done), .timeout(timeout), .upc(upc)
  );

  datapath_sequencer #(.MAX_STEPS(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start2), .banderas(banderas),
    .prog_we(prog_we2), .prog_addr(prog_addr2), .prog_data(prog_data2),
    .control(control2), .busy(busy2), .done(done2), .timeout(timeout2), .upc(upc2)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mw(input logic [1:0] op, input logic [1:0] flag,
                                     input logic [3:0] tgt, input logic [15:0] ctl);
    return {op, flag, tgt, ctl};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input int sel, input logic [15:0] ctl, input logic [3:0] u,
                         input logic chk, input logic b, input logic d, input logic t);
    exp_t e;
    e = '{ctl: ctl, upc: u, chk_upc: chk, busy: b, done: d, tmo: t};
    if (sel == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Caller is positioned just after a rising edge; the write commits on the next one.
  task automatic loadWord(input int sel, input logic [3:0] a, input logic [23:0] d);
    if (sel == 0) begin
      prog_we = 1'b1; prog_addr = a; prog_data = d;
    end else begin
      prog_we2 = 1'b1; prog_addr2 = a; prog_data2 = d;
    end
    @(posedge clk); #1;
    prog_we = 1'b0; prog_we2 = 1'b0;
  endtask

  task automatic applyStimulus(input int sel);
    if (sel == 0) start = 1'b1;
    else start2 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic waitIdle(input int sel, input int limit, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #2;
      if (sel == 0 && q0.size() == 0 && !busy && !done) begin ok = 1'b1; break; end
      if (sel == 1 && q1.size() == 0 && !busy2 && !done2) begin ok = 1'b1; break; end
    end
    checkOutput({name, "_completes"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n && (busy || done)) begin
      if (q0.size() == 0) begin
        checkOutput("dut_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        checkOutput("dut_control", 32'(control), 32'(e.ctl));
        checkOutput("dut_busy", 32'(busy), 32'(e.busy));
        checkOutput("dut_done", 32'(done), 32'(e.done));
        checkOutput("dut_timeout", 32'(timeout), 32'(e.tmo));
        if (e.chk_upc) checkOutput("dut_upc", 32'(upc), 32'(e.upc));
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n && (busy2 || done2)) begin
      if (q1.size() == 0) begin
        checkOutput("dut20_unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        checkOutput("dut20_control", 32'(control2), 32'(e.ctl));
        checkOutput("dut20_busy", 32'(busy2), 32'(e.busy));
        checkOutput("dut20_done", 32'(done2), 32'(e.done));
        checkOutput("dut20_timeout", 32'(timeout2), 32'(e.tmo));
        if (e.chk_upc) checkOutput("dut20_upc", 32'(upc2), 32'(e.upc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    #1;
    checkOutput("reset_control", 32'(control), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_timeout", 32'(timeout), 32'd0);
    checkOutput("reset_upc", 32'(upc), 32'd0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mid-run reset on a self-looping program, monitor off while the run is abandoned.
    mon_en = 1'b0;
    loadWord(0, 4'd0, mw(2'b01, 2'd0, 4'd0, 16'h5A5A));
    applyStimulus(0);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("midrun_busy", 32'(busy), 32'd1);
    checkOutput("midrun_control", 32'(control), 32'h5A5A);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_midrun_control", 32'(control), 32'd0);
    checkOutput("rst_midrun_busy", 32'(busy), 32'd0);
    checkOutput("rst_midrun_upc", 32'(upc), 32'd0);
    checkOutput("rst_midrun_done", 32'(done), 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      checkOutput("post_reset_idle_control", 32'(control), 32'd0);
      checkOutput("post_reset_idle_busy", 32'(busy), 32'd0);
      checkOutput("post_reset_idle_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Straight line of three words.
    loadWord(0, 4'd0, mw(2'b00, 2'd0, 4'd0, 16'h0080));
    loadWord(0, 4'd1, mw(2'b00, 2'd0, 4'd0, 16'h2100));
    loadWord(0, 4'd2, mw(2'b11, 2'd0, 4'd0, 16'h2A10));
    pushExp(0, 16'h0080, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h2100, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h2A10, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(0);
    waitIdle(0, 20, "straight");
    checkOutput("straight_after_control", 32'(control), 32'd0);

    // Branch on flag 2 to word 5, taken then not taken.
    loadWord(0, 4'd0, mw(2'b00, 2'd0, 4'd0, 16'h0011));
    loadWord(0, 4'd1, mw(2'b10, 2'd2, 4'd5, 16'h0022));
    loadWord(0, 4'd2, mw(2'b11, 2'd0, 4'd0, 16'h0033));
    loadWord(0, 4'd5, mw(2'b11, 2'd0, 4'd0, 16'h0055));
    banderas = 4'b0100;
    pushExp(0, 16'h0011, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h0022, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h0055, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(0);
    waitIdle(0, 20, "branch_taken");
    banderas = 4'b0000;
    pushExp(0, 16'h0011, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h0022, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h0033, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(0);
    waitIdle(0, 20, "branch_not_taken");

    // Watchdog on a self-loop: 64 busy cycles, then done with timeout.
    loadWord(0, 4'd0, mw(2'b01, 2'd0, 4'd0, 16'h0A0A));
    for (int i = 0; i < 64; i++) pushExp(0, 16'h0A0A, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(0);
    waitIdle(0, 100, "watchdog");
    checkOutput("timeout_sticky_idle", 32'(timeout), 32'd1);
    loadWord(0, 4'd0, mw(2'b11, 2'd0, 4'd0, 16'h00F0));
    checkOutput("timeout_held_after_load", 32'(timeout), 32'd1);
    pushExp(0, 16'h00F0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(0);
    waitIdle(0, 20, "timeout_clear");

    // Start and a write to word 0 on the same edge.
    pushExp(0, 16'h1234, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(0, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = mw(2'b11, 2'd0, 4'd0, 16'h1234);
    start = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b0; start = 1'b0;
    waitIdle(0, 20, "simultaneous");

    // Wrap 15->0 with a 20-step watchdog; a write during the run must be dropped.
    for (int i = 0; i < 16; i++)
      loadWord(1, 4'(i), mw(2'b00, 2'd0, 4'd0, 16'h0100 + 16'(i)));
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 20; s++)
        pushExp(1, 16'h0100 + 16'(s % 16), 4'(s % 16), 1'b1, 1'b1, 1'b0, 1'b0);
      pushExp(1, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1);
      if (r == 0) begin
        @(posedge clk); #1;
        loadWord(1, 4'd3, mw(2'b11, 2'd0, 4'd0, 16'hDEAD));
      end
      waitIdle(1, 40, "wrap_run");
    end

    checkOutput("scoreboard_dut_drained", 32'(q0.size()), 32'd0);
    checkOutput("scoreboard_dut20_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
